// File: rtl/control_pipe.sv
// Pipelined control unit for the JOF32 5-stage core: decodes once, then carries the
// control bundle through EX, MEM and WB with stall, flush and MULT/DIV occupancy.
module control_pipe #(
    parameter int             OPW        = 5,
    parameter logic [OPW-1:0] NOP_OP     = {OPW{1'b1}},
    parameter int             MUL_CYCLES = 4,
    parameter int             DIV_CYCLES = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode_in,
    input  logic           stall_in,
    input  logic           flush_in,
    output logic [1:0]     sel_dir,
    output logic           reg_rd,
    output logic [1:0]     alu_sel,
    output logic           dir_sl,
    output logic [OPW-1:0] opcode_ex,
    output logic           mem_wr,
    output logic           sel_ld,
    output logic           sel_wb,
    output logic           reg_wr,
    output logic           busy,
    output logic           illegal_op
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
    localparam logic [OPW-1:0] OP_AND  = OPW'(3);
    localparam logic [OPW-1:0] OP_OR   = OPW'(4);
    localparam logic [OPW-1:0] OP_NOR  = OPW'(5);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(6);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(7);
    localparam logic [OPW-1:0] OP_MULT = OPW'(8);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(9);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(10);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(11);
    localparam logic [OPW-1:0] OP_LW   = OPW'(12);
    localparam logic [OPW-1:0] OP_LB   = OPW'(13);
    localparam logic [OPW-1:0] OP_SW   = OPW'(14);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(15);
    localparam logic [OPW-1:0] OP_J    = OPW'(16);

    typedef struct packed {
        logic [1:0] sel_dir;
        logic       reg_rd;
        logic [1:0] alu_sel;
        logic       dir_sl;
        logic       mem_wr;
        logic       sel_ld;
        logic       sel_wb;
        logic       reg_wr;
    } ctrl_t;

    typedef struct packed {
        logic mem_wr;
        logic sel_ld;
        logic sel_wb;
        logic reg_wr;
    } mem_t;

    typedef struct packed {
        logic sel_wb;
        logic reg_wr;
    } wb_t;

    // Bubble bundle; reset state differs only in reg_rd=0.
    localparam ctrl_t NOP_CTRL = 11'b00_1_00_0_0_0_0_0;

    ctrl_t          dec_ctrl;
    logic           dec_illegal;
    logic [CW-1:0]  dec_load;

    ctrl_t          s1_ctrl_reg, s1_ctrl_next;
    logic [OPW-1:0] s1_op_reg,   s1_op_next;
    logic           s1_ill_reg,  s1_ill_next;
    logic [CW-1:0]  cnt_reg,     cnt_next;
    mem_t           s2_reg,      s2_next;
    wb_t            s3_reg,      s3_next;
    mem_t           s1_to_mem;
    logic           busy_int;

    always_comb begin
        dec_ctrl    = NOP_CTRL;
        dec_illegal = 1'b0;
        dec_load    = '0;
        if (opcode_in != NOP_OP) begin
            case (opcode_in)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
                OP_MULT, OP_DIV:  dec_ctrl = 11'b00_1_00_0_0_0_1_1;
                OP_SLL, OP_SRL:   dec_ctrl = 11'b00_1_10_0_0_0_1_1;
                OP_ADDI:          dec_ctrl = 11'b00_1_01_1_0_0_1_1;
                OP_SW:            dec_ctrl = 11'b00_1_01_1_1_0_1_0;
                OP_LW:            dec_ctrl = 11'b00_1_01_1_0_0_0_1;
                OP_LB:            dec_ctrl = 11'b00_1_01_1_0_1_0_1;
                OP_BEQ, OP_BNE:   dec_ctrl = 11'b01_1_01_1_0_0_0_0;
                OP_J:             dec_ctrl = 11'b10_1_01_1_0_0_0_0;
                default:          dec_illegal = 1'b1;
            endcase
            if (opcode_in == OP_MULT)
                dec_load = MUL_LOAD;
            else if (opcode_in == OP_DIV)
                dec_load = DIV_LOAD;
        end
    end

    assign busy_int  = (cnt_reg != '0);
    assign s1_to_mem = '{mem_wr: s1_ctrl_reg.mem_wr, sel_ld: s1_ctrl_reg.sel_ld,
                         sel_wb: s1_ctrl_reg.sel_wb, reg_wr: s1_ctrl_reg.reg_wr};

    // Priority: flush > busy > stall > advance. WB always follows MEM.
    always_comb begin
        s1_ctrl_next = s1_ctrl_reg;
        s1_op_next   = s1_op_reg;
        s1_ill_next  = s1_ill_reg;
        cnt_next     = cnt_reg;
        s2_next      = '0;
        s3_next      = '{sel_wb: s2_reg.sel_wb, reg_wr: s2_reg.reg_wr};
        if (flush_in) begin
            s1_ctrl_next = NOP_CTRL;
            s1_op_next   = NOP_OP;
            s1_ill_next  = 1'b0;
            cnt_next     = '0;
            if (!busy_int)
                s2_next = s1_to_mem;
        end else if (busy_int) begin
            cnt_next = cnt_reg - CW'(1);
        end else if (!stall_in) begin
            s1_ctrl_next = dec_ctrl;
            s1_op_next   = opcode_in;
            s1_ill_next  = dec_illegal;
            cnt_next     = dec_load;
            s2_next      = s1_to_mem;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_ctrl_reg <= '0;
            s1_op_reg   <= NOP_OP;
            s1_ill_reg  <= 1'b0;
            cnt_reg     <= '0;
            s2_reg      <= '0;
            s3_reg      <= '0;
        end else begin
            s1_ctrl_reg <= s1_ctrl_next;
            s1_op_reg   <= s1_op_next;
            s1_ill_reg  <= s1_ill_next;
            cnt_reg     <= cnt_next;
            s2_reg      <= s2_next;
            s3_reg      <= s3_next;
        end
    end

    assign sel_dir    = s1_ctrl_reg.sel_dir;
    assign reg_rd     = s1_ctrl_reg.reg_rd;
    assign alu_sel    = s1_ctrl_reg.alu_sel;
    assign dir_sl     = s1_ctrl_reg.dir_sl;
    assign opcode_ex  = s1_op_reg;
    assign illegal_op = s1_ill_reg;
    assign busy       = busy_int;
    assign mem_wr     = s2_reg.mem_wr;
    assign sel_ld     = s2_reg.sel_ld;
    assign sel_wb     = s3_reg.sel_wb;
    assign reg_wr     = s3_reg.reg_wr;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: decode rows, stage latency, MULT occupancy,
// stall, flush of a busy DIV, illegal opcode and asynchronous reset.
module tb_control_pipe;

    localparam int OPW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [OPW-1:0] opcode_in;
    logic           stall_in;
    logic           flush_in;
    logic [1:0]     sel_dir;
    logic           reg_rd;
    logic [1:0]     alu_sel;
    logic           dir_sl;
    logic [OPW-1:0] opcode_ex;
    logic           mem_wr;
    logic           sel_ld;
    logic           sel_wb;
    logic           reg_wr;
    logic           busy;
    logic           illegal_op;

    logic [5:0] ex_vec;
    logic [1:0] mem_vec;
    logic [1:0] wb_vec;

    int checks = 0;
    int errors = 0;

    control_pipe #(
        .OPW(OPW), .NOP_OP(5'd31), .MUL_CYCLES(4), .DIV_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .opcode_in(opcode_in), .stall_in(stall_in),
        .flush_in(flush_in), .sel_dir(sel_dir), .reg_rd(reg_rd), .alu_sel(alu_sel),
        .dir_sl(dir_sl), .opcode_ex(opcode_ex), .mem_wr(mem_wr), .sel_ld(sel_ld),
        .sel_wb(sel_wb), .reg_wr(reg_wr), .busy(busy), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    assign ex_vec  = {sel_dir, reg_rd, alu_sel, dir_sl};
    assign mem_vec = {mem_wr, sel_ld};
    assign wb_vec  = {sel_wb, reg_wr};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t op_in=%0d stall=%0b flush=%0b | op_ex=%0d ex=%b mem=%b wb=%b busy=%0b ill=%0b",
                 $time, opcode_in, stall_in, flush_in, opcode_ex, ex_vec, mem_vec, wb_vec,
                 busy, illegal_op);
    endtask

    // Test 2: ADD LW SW BEQ J then NOP
    logic [OPW-1:0] t2_op  [6] = '{5'd1, 5'd12, 5'd14, 5'd10, 5'd16, 5'd31};
    logic [5:0]     t2_ex  [6] = '{6'b001000, 6'b001011, 6'b001011, 6'b011011, 6'b101011, 6'b001000};
    logic [1:0]     t2_mem [6] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0]     t2_wb  [6] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};

    // Test 3: MULT held 4 clocks, ADD waits upstream
    logic [OPW-1:0] t3_in  [6] = '{5'd8, 5'd1, 5'd1, 5'd1, 5'd1, 5'd31};
    logic [OPW-1:0] t3_ex  [6] = '{5'd8, 5'd8, 5'd8, 5'd8, 5'd1, 5'd31};
    logic           t3_bsy [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]     t3_wb  [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};

    initial begin
        rst       = 1'b1;
        opcode_in = 5'd31;
        stall_in  = 1'b0;
        flush_in  = 1'b0;
        tick();
        tick();
        check("rst_op_ex", 32'(opcode_ex), 32'd31);
        check("rst_ex",    32'(ex_vec),    32'd0);
        check("rst_memwb", 32'({mem_vec, wb_vec}), 32'd0);
        check("rst_busy_ill", 32'({busy, illegal_op}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            opcode_in = t2_op[i];
            tick();
            check($sformatf("t2_op_ex[%0d]", i), 32'(opcode_ex), 32'(t2_op[i]));
            check($sformatf("t2_ex[%0d]", i),    32'(ex_vec),    32'(t2_ex[i]));
            check($sformatf("t2_mem[%0d]", i),   32'(mem_vec),   (i >= 1) ? 32'(t2_mem[i-1]) : 32'd0);
            check($sformatf("t2_wb[%0d]", i),    32'(wb_vec),    (i >= 2) ? 32'(t2_wb[i-2]) : 32'd0);
        end

        for (int i = 0; i < 6; i++) begin
            opcode_in = t3_in[i];
            tick();
            check($sformatf("t3_op_ex[%0d]", i), 32'(opcode_ex), 32'(t3_ex[i]));
            check($sformatf("t3_busy[%0d]", i),  32'(busy),      32'(t3_bsy[i]));
            check($sformatf("t3_wb[%0d]", i),    32'(wb_vec),    32'(t3_wb[i]));
        end

        // Test 4: LB stalled two cycles
        opcode_in = 5'd13;
        tick();
        check("t4_lb_ex", 32'(ex_vec), 32'b001011);
        opcode_in = 5'd1;
        stall_in  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("t4_hold_op[%0d]", i), 32'(opcode_ex), 32'd13);
            check($sformatf("t4_mem_nop[%0d]", i), 32'(mem_vec),   32'b00);
        end
        stall_in = 1'b0;
        tick();
        check("t4_add_ex", 32'(opcode_ex), 32'd1);
        check("t4_lb_mem", 32'(mem_vec),   32'b01);
        opcode_in = 5'd31;
        tick();
        check("t4_lb_wb", 32'(wb_vec), 32'b01);

        // Test 5: DIV flushed on its second EX cycle
        opcode_in = 5'd9;
        tick();
        check("t5_div_busy", 32'(busy), 32'd1);
        opcode_in = 5'd1;
        flush_in  = 1'b1;
        tick();
        check("t5_flush_op", 32'(opcode_ex), 32'd31);
        check("t5_flush_busy", 32'(busy), 32'd0);
        flush_in  = 1'b0;
        opcode_in = 5'd31;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("t5_no_div_wb[%0d]", i), 32'(wb_vec), 32'b00);
            check($sformatf("t5_no_busy[%0d]", i),   32'(busy),   32'd0);
        end

        // Test 6: undefined opcode 21
        opcode_in = 5'd21;
        tick();
        check("t6_ill", 32'(illegal_op), 32'd1);
        check("t6_op_ex", 32'(opcode_ex), 32'd21);
        check("t6_ex_nop", 32'(ex_vec), 32'b001000);
        opcode_in = 5'd31;
        tick();
        check("t6_ill_clr", 32'(illegal_op), 32'd0);
        check("t6_mem", 32'(mem_vec), 32'b00);
        tick();
        check("t6_wb", 32'(wb_vec), 32'b00);

        // Test 1: asynchronous reset mid-stream with SW in MEM and MULT busy
        opcode_in = 5'd14;
        tick();
        opcode_in = 5'd8;
        tick();
        check("t1_pre_mem", 32'(mem_vec), 32'b10);
        check("t1_pre_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t1_op_ex", 32'(opcode_ex), 32'd31);
        check("t1_ex", 32'(ex_vec), 32'd0);
        check("t1_memwb", 32'({mem_vec, wb_vec}), 32'd0);
        check("t1_busy_ill", 32'({busy, illegal_op}), 32'd0);
        tick();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
